// File: rtl/atmos_frame_ctrl_if.sv
// Video-stream and host-threshold bus of the atmospheric-light frame controller.
// The source (video pipe + host) uses the master side and the controller uses the slave side.
interface atmos_frame_ctrl_if;
  logic [7:0] i_dark;
  logic       i_vsync;
  logic       i_de;
  logic       cfg_valid;
  logic [7:0] cfg_thre;
  logic       cfg_ready;

  modport master (
    output i_dark, i_vsync, i_de, cfg_valid, cfg_thre,
    input  cfg_ready
  );

  modport slave (
    input  i_dark, i_vsync, i_de, cfg_valid, cfg_thre,
    output cfg_ready
  );
endinterface

// File: rtl/atmos_frame_ctrl.sv
// Frame-level controller for the transmittance stage.
// It tracks the per-frame dark-channel maximum and smooths it into the atmospheric light A.
// It derives the scaling-table index K_sel from A.
// A, K_sel and t0 are published together, once per accepted frame.
module atmos_frame_ctrl #(
  parameter int unsigned ALPHA_SHIFT = 32'd2,
  parameter int unsigned INIT_A      = 32'd200,
  parameter int unsigned INIT_THRE   = 32'd26,
  parameter int unsigned MIN_PIXELS  = 32'd1024,
  parameter int unsigned TIMEOUT     = 32'd4194304
) (
  input  logic                 pixelclk,
  input  logic                 reset_n,
  atmos_frame_ctrl_if.slave    bus,
  output logic [7:0]           o_atmos,
  output logic [3:0]           o_k_sel,
  output logic [7:0]           o_thre,
  output logic                 o_cfg_update,
  output logic                 o_frame_err,
  output logic                 o_locked,
  output logic                 o_timeout
);

  localparam int unsigned      WD_W        = $clog2(TIMEOUT + 32'd1);
  localparam logic [WD_W-1:0]  TIMEOUT_C   = WD_W'(TIMEOUT);
  localparam logic [7:0]       INIT_A_C    = 8'(INIT_A);
  localparam logic [7:0]       INIT_THRE_C = 8'(INIT_THRE);
  localparam logic [23:0]      MIN_PIX_C   = 24'(MIN_PIXELS);
  localparam logic [23:0]      PIX_SAT_C   = 24'hFF_FFFF;

  // Scaling-table index: brighter atmosphere selects a lower index.
  function automatic logic [3:0] k_index(input logic [7:0] a);
    logic [3:0] k;
    if      (a > 8'd240) k = 4'd0;
    else if (a > 8'd230) k = 4'd1;
    else if (a > 8'd220) k = 4'd2;
    else if (a > 8'd210) k = 4'd3;
    else if (a > 8'd200) k = 4'd4;
    else if (a > 8'd190) k = 4'd5;
    else if (a > 8'd180) k = 4'd6;
    else if (a > 8'd170) k = 4'd7;
    else if (a > 8'd160) k = 4'd8;
    else                 k = 4'd9;
    return k;
  endfunction

  // One IIR step. The arithmetic shift rounds toward -inf, and the result is clamped to 8 bits.
  function automatic logic [7:0] iir_step(input logic [7:0] a, input logic [7:0] fm);
    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic signed [9:0] sum;
    logic [7:0]        res;
    diff = $signed({1'b0, fm}) - $signed({1'b0, a});
    step = diff >>> ALPHA_SHIFT;
    sum  = $signed({2'b00, a}) + $signed({step[8], step});
    if (sum < 10'sd0)        res = 8'd0;
    else if (sum > 10'sd255) res = 8'hFF;
    else                     res = sum[7:0];
    return res;
  endfunction

  localparam logic [3:0] INIT_K_C = k_index(INIT_A_C);

  typedef enum logic [1:0] {ST_WAIT, ST_ACTIVE, ST_UPDATE, ST_APPLY} state_t;

  state_t           state_q, state_d;
  logic [7:0]       dark_q;
  logic             vs_q, vs_dly_q, de_q;
  logic [7:0]       run_max_q, run_max_d;
  logic [23:0]      pix_cnt_q, pix_cnt_d;
  logic [7:0]       frame_max_q, frame_max_d;
  logic [23:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       a_next_q, a_next_d;
  logic [3:0]       k_next_q, k_next_d;
  logic [7:0]       atmos_q, atmos_d;
  logic [3:0]       k_sel_q, k_sel_d;
  logic [7:0]       thre_q, thre_d;
  logic             upd_q, upd_d;
  logic             ferr_q, ferr_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             ready_q, ready_d;

  logic             vs_edge_s, frame_ok_s, accept_s;
  logic             snap_s, calc_s, err_s, apply_s;
  logic [7:0]       pix_max_s, a_calc_s;
  logic [23:0]      pix_cnt_inc_s;

  assign vs_edge_s  = vs_q & ~vs_dly_q;
  assign frame_ok_s = (frame_cnt_q >= MIN_PIX_C);
  assign accept_s   = bus.cfg_valid & ready_q;

  // FSM state register.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_WAIT;
    else          state_q <= state_d;
  end

  // FSM next state: an edge in UPDATE/APPLY never re-enters UPDATE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:   state_d = vs_edge_s ? ST_ACTIVE : ST_WAIT;
      ST_ACTIVE: state_d = vs_edge_s ? ST_UPDATE : ST_ACTIVE;
      ST_UPDATE: state_d = frame_ok_s ? ST_APPLY : ST_ACTIVE;
      ST_APPLY:  state_d = ST_ACTIVE;
      default:   state_d = ST_WAIT;
    endcase
  end

  // FSM outputs: snapshot, compute, reject and publish strobes.
  always_comb begin
    snap_s  = 1'b0;
    calc_s  = 1'b0;
    err_s   = 1'b0;
    apply_s = 1'b0;
    case (state_q)
      ST_WAIT:   snap_s = 1'b0;
      ST_ACTIVE: snap_s = vs_edge_s;
      ST_UPDATE: begin
        snap_s = vs_edge_s;
        calc_s = frame_ok_s;
        err_s  = ~frame_ok_s;
      end
      ST_APPLY: begin
        snap_s  = vs_edge_s;
        apply_s = 1'b1;
      end
      default: snap_s = 1'b0;
    endcase
  end

  // Datapath next state: statistics, A computation, publishing, host pending slot, watchdog.
  always_comb begin
    // The pixel sampled in the edge cycle still belongs to the ending frame.
    pix_max_s     = (de_q && (dark_q > run_max_q)) ? dark_q : run_max_q;
    pix_cnt_inc_s = (de_q && (pix_cnt_q != PIX_SAT_C)) ? (pix_cnt_q + 24'd1) : pix_cnt_q;
    a_calc_s      = locked_q ? iir_step(atmos_q, frame_max_q) : frame_max_q;

    if (vs_edge_s) begin
      run_max_d = 8'd0;
      pix_cnt_d = 24'd0;
    end else begin
      run_max_d = pix_max_s;
      pix_cnt_d = pix_cnt_inc_s;
    end

    if (snap_s) begin
      frame_max_d = pix_max_s;
      frame_cnt_d = pix_cnt_inc_s;
    end else begin
      frame_max_d = frame_max_q;
      frame_cnt_d = frame_cnt_q;
    end

    if (calc_s) begin
      a_next_d = a_calc_s;
      k_next_d = k_index(a_calc_s);
    end else begin
      a_next_d = a_next_q;
      k_next_d = k_next_q;
    end

    if (apply_s) begin
      atmos_d  = a_next_q;
      k_sel_d  = k_next_q;
      thre_d   = pend_full_q ? pend_q : thre_q;
      upd_d    = 1'b1;
      locked_d = 1'b1;
    end else begin
      atmos_d  = atmos_q;
      k_sel_d  = k_sel_q;
      thre_d   = thre_q;
      upd_d    = 1'b0;
      locked_d = locked_q;
    end
    ferr_d = err_s;

    // A write accepted during APPLY stays pending, because the slot was empty when APPLY read it.
    if (apply_s && pend_full_q) begin
      pend_full_d = 1'b0;
    end else if (accept_s) begin
      pend_full_d = 1'b1;
    end else begin
      pend_full_d = pend_full_q;
    end
    pend_d  = accept_s ? bus.cfg_thre : pend_q;
    ready_d = ~pend_full_d;

    if (vs_edge_s) begin
      wd_cnt_d  = {WD_W{1'b0}};
      timeout_d = 1'b0;
    end else if (wd_cnt_q == TIMEOUT_C) begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = 1'b1;
    end else begin
      wd_cnt_d  = wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
      timeout_d = timeout_q | (wd_cnt_d == TIMEOUT_C);
    end
  end

  // Input sampling and all datapath/output registers.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      dark_q      <= 8'd0;
      vs_q        <= 1'b0;
      vs_dly_q    <= 1'b0;
      de_q        <= 1'b0;
      run_max_q   <= 8'd0;
      pix_cnt_q   <= 24'd0;
      frame_max_q <= 8'd0;
      frame_cnt_q <= 24'd0;
      a_next_q    <= INIT_A_C;
      k_next_q    <= INIT_K_C;
      atmos_q     <= INIT_A_C;
      k_sel_q     <= INIT_K_C;
      thre_q      <= INIT_THRE_C;
      upd_q       <= 1'b0;
      ferr_q      <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      wd_cnt_q    <= {WD_W{1'b0}};
      pend_q      <= 8'd0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      dark_q      <= bus.i_dark;
      vs_q        <= bus.i_vsync;
      vs_dly_q    <= vs_q;
      de_q        <= bus.i_de;
      run_max_q   <= run_max_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_max_q <= frame_max_d;
      frame_cnt_q <= frame_cnt_d;
      a_next_q    <= a_next_d;
      k_next_q    <= k_next_d;
      atmos_q     <= atmos_d;
      k_sel_q     <= k_sel_d;
      thre_q      <= thre_d;
      upd_q       <= upd_d;
      ferr_q      <= ferr_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      wd_cnt_q    <= wd_cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.cfg_ready = ready_q;
  assign o_atmos       = atmos_q;
  assign o_k_sel       = k_sel_q;
  assign o_thre        = thre_q;
  assign o_cfg_update  = upd_q;
  assign o_frame_err   = ferr_q;
  assign o_locked      = locked_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_atmos_frame_ctrl.sv
// Scoreboard bench for atmos_frame_ctrl.
// Every frame boundary pushes the expected publish or reject event with its expected cycle.
// A negedge monitor pops each event and checks it, then checks that the published outputs held.
module tb_atmos_frame_ctrl;
  localparam int TO = 5000;

  logic       pixelclk = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] o_atmos;
  logic [3:0] o_k_sel;
  logic [7:0] o_thre;
  logic       o_cfg_update, o_frame_err, o_locked, o_timeout;

  atmos_frame_ctrl_if bus ();

  atmos_frame_ctrl #(
    .ALPHA_SHIFT(2), .INIT_A(200), .INIT_THRE(26), .MIN_PIXELS(1024), .TIMEOUT(TO)
  ) dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .bus(bus),
    .o_atmos(o_atmos), .o_k_sel(o_k_sel), .o_thre(o_thre),
    .o_cfg_update(o_cfg_update), .o_frame_err(o_frame_err),
    .o_locked(o_locked), .o_timeout(o_timeout)
  );

  always #5 pixelclk = ~pixelclk;

  int unsigned cyc = 0;
  always @(posedge pixelclk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          err;
    logic [7:0]  a;
    logic [3:0]  k;
    logic [7:0]  t;
    int unsigned cyc;
  } evt_t;
  evt_t sb[$];

  // Reference model state
  int m_a = 200, m_thre = 26, m_pend = 0;
  bit m_pend_full = 0, m_locked = 0, m_started = 0;

  // Published values as seen by the monitor
  logic [7:0] p_a = 8'd200, p_t = 8'd26;
  logic [3:0] p_k = 4'd5;
  logic       p_l = 1'b0;

  function automatic logic [3:0] ref_k(input int a);
    int thr[9];
    thr = '{240, 230, 220, 210, 200, 190, 180, 170, 160};
    for (int i = 0; i < 9; i++) if (a > thr[i]) return 4'(i);
    return 4'd9;
  endfunction

  // floor((fm - a) / 4), i.e. the smoothing step for shift 2
  function automatic int ref_iir(input int a, input int fm);
    int d;
    d = fm - a;
    if (d >= 0) return a + d / 4;
    return a - ((-d + 3) / 4);
  endfunction

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic model_boundary(input int npix, input int fmax);
    evt_t e;
    if (!m_started) begin
      m_started = 1;
    end else if (npix < 1024) begin
      e.err = 1; e.a = 8'(m_a); e.k = ref_k(m_a); e.t = 8'(m_thre); e.cyc = cyc + 3;
      sb.push_back(e);
    end else begin
      m_a = m_locked ? ref_iir(m_a, fmax) : fmax;
      m_locked = 1;
      if (m_pend_full) begin
        m_thre = m_pend;
        m_pend_full = 0;
      end
      e.err = 0; e.a = 8'(m_a); e.k = ref_k(m_a); e.t = 8'(m_thre); e.cyc = cyc + 4;
      sb.push_back(e);
    end
  endtask

  // Lines of 64 active pixels separated by 8 blank cycles. Blank cycles carry dark=255, which must be ignored.
  task automatic send_pixels(input int npix, input int maxv);
    int pos;
    pos = $urandom_range(0, npix - 1);
    for (int i = 0; i < npix; i++) begin
      tick();
      bus.i_de   = 1'b1;
      bus.i_dark = (i == pos) ? 8'(maxv) : 8'($urandom_range(0, maxv));
      if (i % 64 == 63) begin
        tick();
        bus.i_de = 1'b0; bus.i_dark = 8'hFF;
        repeat (7) tick();
      end
    end
    tick();
    bus.i_de = 1'b0; bus.i_dark = 8'hFF;
  endtask

  task automatic vsync_pulse(input int npix, input int fmax);
    tick();
    bus.i_vsync = 1'b1;
    model_boundary(npix, fmax);
    repeat (4) tick();
    bus.i_vsync = 1'b0;
    repeat (8) tick();
  endtask

  task automatic host_write();
    repeat (200) tick();
    chk("rdy_before_wr", {31'd0, bus.cfg_ready}, 32'd1);
    bus.cfg_valid = 1'b1; bus.cfg_thre = 8'd40;
    tick();
    chk("rdy_drop", {31'd0, bus.cfg_ready}, 32'd0);
    m_pend = 40; m_pend_full = 1;
    bus.cfg_thre = 8'd77;
    repeat (5) begin
      tick();
      chk("rdy_held_off", {31'd0, bus.cfg_ready}, 32'd0);
    end
    bus.cfg_valid = 1'b0;
    tick();
    chk("thre_before_bnd", {24'd0, o_thre}, 32'd26);
  endtask

  // Monitor: pop and check each event, then check that the published outputs held
  initial begin
    evt_t e;
    forever begin
      @(negedge pixelclk);
      if (!reset_n) begin
        sb.delete();
        p_a = 8'd200; p_k = 4'd5; p_t = 8'd26; p_l = 1'b0;
      end else begin
        if (o_cfg_update || o_frame_err) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected", {30'd0, o_cfg_update, o_frame_err}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("evt_kind", {30'd0, o_cfg_update, o_frame_err}, e.err ? 32'd1 : 32'd2);
            chk("evt_cycle", cyc, e.cyc);
            if (!e.err) begin
              p_a = e.a; p_k = e.k; p_t = e.t; p_l = 1'b1;
              chk("rdy_after_apply", {31'd0, bus.cfg_ready}, 32'd1);
            end
          end
        end
        chk("hold", {11'd0, o_atmos, o_k_sel, o_thre, o_locked}, {11'd0, p_a, p_k, p_t, p_l});
      end
    end
  end

  initial begin
    int n;
    bus.i_dark = 8'd0; bus.i_vsync = 1'b0; bus.i_de = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_thre = 8'd0;
    repeat (3) tick();
    chk("rst_atmos",  {24'd0, o_atmos}, 32'd200);
    chk("rst_ksel",   {28'd0, o_k_sel}, 32'd5);
    chk("rst_thre",   {24'd0, o_thre},  32'd26);
    chk("rst_ready",  {31'd0, bus.cfg_ready}, 32'd1);
    chk("rst_pulses", {30'd0, o_cfg_update, o_frame_err}, 32'd0);
    chk("rst_locked", {31'd0, o_locked},  32'd0);
    chk("rst_timeout",{31'd0, o_timeout}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Partial first frame is discarded: WAIT -> ACTIVE without any pulse
    send_pixels(2048, 120); vsync_pulse(2048, 120);
    chk("unlocked_after_wait", {31'd0, o_locked}, 32'd0);
    send_pixels(2048, 230); vsync_pulse(2048, 230);   // 230, k2
    chk("locked_first", {31'd0, o_locked}, 32'd1);
    send_pixels(2048, 190); vsync_pulse(2048, 190);   // 220, k3
    send_pixels(2048, 240); vsync_pulse(2048, 240);   // 225, k2
    send_pixels(2048, 150); vsync_pulse(2048, 150);   // 206, k4 (floor of -18.75)
    send_pixels(500, 255);  vsync_pulse(500, 255);    // rejected

    // Host write mid-frame; this frame is exactly MIN_PIXELS long
    fork
      send_pixels(1024, 206);
      host_write();
    join
    vsync_pulse(1024, 206);                            // 206, k4, thre 40

    // Watchdog
    chk("to_low", {31'd0, o_timeout}, 32'd0);
    repeat (4800) tick();
    chk("to_early", {31'd0, o_timeout}, 32'd0);
    n = 0;
    while (o_timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("to_rise", {31'd0, o_timeout}, 32'd1);
    repeat (20) tick();
    chk("to_sticky", {31'd0, o_timeout}, 32'd1);
    send_pixels(2048, 255);
    chk("to_sticky_frame", {31'd0, o_timeout}, 32'd1);
    vsync_pulse(2048, 255);                            // 218, k3
    chk("to_clear", {31'd0, o_timeout}, 32'd0);

    // Asynchronous reset mid-frame: outputs return without any clock edge
    send_pixels(1000, 250);
    @(posedge pixelclk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_atmos",  {24'd0, o_atmos}, 32'd200);
    chk("arst_ksel",   {28'd0, o_k_sel}, 32'd5);
    chk("arst_thre",   {24'd0, o_thre},  32'd26);
    chk("arst_locked", {31'd0, o_locked}, 32'd0);
    chk("arst_ready",  {31'd0, bus.cfg_ready}, 32'd1);
    m_a = 200; m_thre = 26; m_locked = 0; m_started = 0; m_pend_full = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    send_pixels(1048, 250); vsync_pulse(1048, 250);   // discarded partial frame
    chk("unlocked_post_rst", {31'd0, o_locked}, 32'd0);
    send_pixels(2048, 180); vsync_pulse(2048, 180);   // 180 unsmoothed, k7, thre 26
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
